// File: rtl/arb_types.sv
// arb_types: shared state/owner encodings for the cache memory arbiter.
package arb_types;
  typedef enum bit [1:0] {ARB_IDLE = 2'b00, ARB_ICACHE = 2'b01, ARB_DCACHE = 2'b10} arb_state_t;
  typedef enum bit {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;
endpackage

// File: rtl/cache_arb_pick.sv
// cache_arb_pick: chooses which cache gets the next pmem grant.
// Fixed D-cache priority unless CACHE_ARB_ROUND_ROBIN_EN alternates contended grants.
module cache_arb_pick
  import arb_types::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic last_owner,
  output logic grant_valid,
  output logic grant_owner
);
  assign grant_valid = i_req | d_req;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
  assign grant_owner = (i_req && d_req) ? (last_owner == OWN_I) : d_req;
`else
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
  assign grant_owner = d_req;
`endif
endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one pmem cacheline port between I-cache and D-cache misses.
// Optional CACHE_ARB_ROUND_ROBIN_EN replaces fixed D priority with alternation on contention.
module cache_mem_arbiter
  import arb_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_pmem_address,
  input  logic              i_pmem_read,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic [ADDR_W-1:0] pmem_address,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [1:0]        arb_owner
);
  arb_state_t state_q, state_d;
  logic grant_valid, grant_owner, last_owner;
  cache_arb_pick u_pick (
    .i_req      (i_pmem_read),
    .d_req      (d_pmem_read | d_pmem_write),
    .last_owner (last_owner),
    .grant_valid(grant_valid),
    .grant_owner(grant_owner)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ARB_IDLE;
    else        state_q <= state_d;
  end
`ifdef CACHE_ARB_ROUND_ROBIN_EN
  logic last_owner_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_owner_q <= OWN_I;
    else if (state_q == ARB_IDLE && grant_valid) last_owner_q <= grant_owner;
  end
  assign last_owner = last_owner_q;
`else
  assign last_owner = OWN_I;
`endif
  // pmem_rdata is broadcast; only the owner's resp is ever steered through
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;
  assign arb_owner    = state_q;
  always_comb begin
    state_d      = state_q;
    pmem_address = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_wdata   = '0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    case (state_q)
      ARB_IDLE:
        if (grant_valid) state_d = grant_owner ? ARB_DCACHE : ARB_ICACHE;
      ARB_ICACHE: begin
        pmem_address = i_pmem_address;
        pmem_read    = i_pmem_read;
        i_pmem_resp  = pmem_resp;
        state_d      = pmem_resp ? ARB_IDLE : ARB_ICACHE;
      end
      ARB_DCACHE: begin
        pmem_address = d_pmem_address;
        pmem_read    = d_pmem_read;
        pmem_write   = d_pmem_write;
        pmem_wdata   = d_pmem_wdata;
        d_pmem_resp  = pmem_resp;
        state_d      = pmem_resp ? ARB_IDLE : ARB_DCACHE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed checks of grant, routing, resp steering, reset and contention.
module tb_cache_mem_arbiter;
  import arb_types::*;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  i_pmem_address, d_pmem_address, pmem_address;
  logic         i_pmem_read, i_pmem_resp, d_pmem_read, d_pmem_write, d_pmem_resp;
  logic [255:0] i_pmem_rdata, d_pmem_rdata, d_pmem_wdata, pmem_wdata, pmem_rdata;
  logic         pmem_read, pmem_write, pmem_resp;
  logic [1:0]   arb_owner;
  int n_assert = 0;
  int n_fail = 0;
  logic [1:0] exp_own [4];

  cache_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_pmem_address(i_pmem_address), .i_pmem_read(i_pmem_read),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_address(d_pmem_address), .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_wdata(d_pmem_wdata), .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .arb_owner(arb_owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic close_txn();
    @(posedge clk);
    #1;
    pmem_resp = 1'b0;
    i_pmem_read = 1'b0;
    d_pmem_read = 1'b0;
    d_pmem_write = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    i_pmem_address = '0; i_pmem_read = 1'b0;
    d_pmem_address = '0; d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_wdata = '0;
    pmem_rdata = {8{32'hDEAD_BEEF}}; pmem_resp = 1'b0;
    cyc(); cyc();
    chk("rst_owner", arb_owner, ARB_IDLE);
    chk("rst_read", pmem_read, 1'b0);
    chk("rst_write", pmem_write, 1'b0);
    chk("rst_addr", pmem_address, 32'h0);
    rst_n = 1'b1;
    cyc();
    // lone I-cache miss, 8-cycle burst
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1040;
    chk("i_pre_grant_read", pmem_read, 1'b0);
    cyc();
    chk("i_owner", arb_owner, ARB_ICACHE);
    chk("i_read", pmem_read, 1'b1);
    chk("i_addr", pmem_address, 32'h0000_1040);
    chk("i_write", pmem_write, 1'b0);
    repeat (8) cyc();
    chk("i_hold_owner", arb_owner, ARB_ICACHE);
    pmem_resp = 1'b1; #1;
    chk("i_resp", i_pmem_resp, 1'b1);
    chk("i_d_resp", d_pmem_resp, 1'b0);
    chk("i_rdata", i_pmem_rdata, {8{32'hDEAD_BEEF}});
    chk("d_rdata_bcast", d_pmem_rdata, {8{32'hDEAD_BEEF}});
    close_txn();
    chk("i_after_idle", arb_owner, ARB_IDLE);
    // stray resp while idle
    pmem_resp = 1'b1; #1;
    chk("stray_i_resp", i_pmem_resp, 1'b0);
    chk("stray_d_resp", d_pmem_resp, 1'b0);
    close_txn();
    chk("stray_owner", arb_owner, ARB_IDLE);
    // D-cache writeback
    d_pmem_write = 1'b1; d_pmem_address = 32'h8000_0020; d_pmem_wdata = {32{8'hA5}};
    cyc();
    chk("d_owner", arb_owner, ARB_DCACHE);
    chk("d_write", pmem_write, 1'b1);
    chk("d_read", pmem_read, 1'b0);
    chk("d_addr", pmem_address, 32'h8000_0020);
    chk("d_wdata", pmem_wdata, {32{8'hA5}});
    cyc(); cyc();
    pmem_resp = 1'b1; #1;
    chk("d_resp", d_pmem_resp, 1'b1);
    chk("d_i_resp", i_pmem_resp, 1'b0);
    close_txn();
    chk("d_after_idle", arb_owner, ARB_IDLE);
    // contention: D first, mandatory idle, then I
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_2000;
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_3000;
    cyc();
    chk("con_owner_d", arb_owner, ARB_DCACHE);
    chk("con_addr_d", pmem_address, 32'h0000_3000);
    cyc();
    pmem_resp = 1'b1; #1;
    chk("con_d_resp", d_pmem_resp, 1'b1);
    chk("con_i_resp_quiet", i_pmem_resp, 1'b0);
    @(posedge clk); #1;
    pmem_resp = 1'b0; d_pmem_read = 1'b0;
    @(negedge clk);
    chk("con_idle_gap", arb_owner, ARB_IDLE);
    chk("con_idle_read", pmem_read, 1'b0);
    cyc();
    chk("con_owner_i", arb_owner, ARB_ICACHE);
    chk("con_addr_i", pmem_address, 32'h0000_2000);
    pmem_resp = 1'b1; #1;
    chk("con_i_resp", i_pmem_resp, 1'b1);
    close_txn();
    // illegal read+write passes straight through
    d_pmem_read = 1'b1; d_pmem_write = 1'b1; d_pmem_address = 32'h0000_4000;
    cyc();
    chk("rw_read", pmem_read, 1'b1);
    chk("rw_write", pmem_write, 1'b1);
    pmem_resp = 1'b1; #1;
    close_txn();
    // reset mid D write clears outputs without waiting for the clock
    d_pmem_write = 1'b1; d_pmem_address = 32'h8000_0040; d_pmem_wdata = {32{8'h5A}};
    cyc();
    chk("mid_owner", arb_owner, ARB_DCACHE);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_write", pmem_write, 1'b0);
    chk("mid_rst_owner", arb_owner, ARB_IDLE);
    chk("mid_rst_addr", pmem_address, 32'h0);
    chk("mid_rst_wdata", pmem_wdata, 256'h0);
    @(posedge clk); #1;
    d_pmem_write = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_owner", arb_owner, ARB_IDLE);
    // four contended transactions with both requests held
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    exp_own = '{ARB_DCACHE, ARB_ICACHE, ARB_DCACHE, ARB_ICACHE};
`else
    exp_own = '{ARB_DCACHE, ARB_DCACHE, ARB_DCACHE, ARB_DCACHE};
`endif
    i_pmem_read = 1'b1; d_pmem_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk($sformatf("rr_owner%0d", k), arb_owner, exp_own[k]);
      pmem_resp = 1'b1; #1;
      chk($sformatf("rr_i_resp%0d", k), i_pmem_resp, exp_own[k] == ARB_ICACHE);
      chk($sformatf("rr_d_resp%0d", k), d_pmem_resp, exp_own[k] == ARB_DCACHE);
      @(posedge clk); #1;
      pmem_resp = 1'b0;
      @(negedge clk);
      chk($sformatf("rr_idle%0d", k), arb_owner, ARB_IDLE);
    end
    i_pmem_read = 1'b0; d_pmem_read = 1'b0;
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
